plab4_net_sd_eject_buf: RTL and testbench

- Ejection-side buffer on one terminal output port of the security-domain ring network.
- Consumes the per-port out_val/out_rdy/out_msg stream. That stream is time-multiplexed between two security domains by the network's toggling cur_sd bit.
- Sorts each accepted message into one of two per-domain FIFOs, domain 0 or domain 1, and presents each FIFO to its own domain's consumer through an independent val/rdy interface.
- Backpressure to the network for domain d depends only on domain d's FIFO state. One domain's consumer therefore never affects the other domain's acceptance timing.

---
 rtl/plab4_net_sd_eject_buf.sv | 145 ++++++++++++++
 tb/tb_plab4_net_sd_eject_buf.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/plab4_net_sd_eject_buf.sv
//------------------------------------------------------------------------
// plab4_net_sd_eject_buf
//------------------------------------------------------------------------
// Ejection-side buffer for one terminal port of the security-domain ring.
// The network stream is time-multiplexed between two security domains by
// cur_sd. Each accepted message is sorted into a per-domain FIFO, and each
// FIFO drives its own domain's val/rdy consumer interface. Acceptance for
// domain d depends only on FIFO d, so one domain's consumer can never
// change when the other domain's messages are accepted.
//
// Ports:
//   clk, reset           clock; asynchronous active-high reset
//   cur_sd               security domain the network serves this cycle
//   net_val/net_rdy/net_msg
//                        network-side stream for domain cur_sd
//   out_val_d/out_rdy_d/out_msg_d (d = 0, 1)
//                        per-domain consumer stream (FIFO head)
//   count_0, count_1     per-domain FIFO occupancy
//
// p_num_entries must be a power of two and at least 2.
//------------------------------------------------------------------------

module plab4_net_sd_eject_buf #(
  parameter int unsigned p_payload_nbits = 32,
  parameter int unsigned p_opaque_nbits  = 3,
  parameter int unsigned p_srcdest_nbits = 3,
  parameter int unsigned p_num_entries   = 2,

  localparam int unsigned m           = p_payload_nbits + p_opaque_nbits
                                        + 2 * p_srcdest_nbits,
  localparam int unsigned c_cnt_nbits = $clog2(p_num_entries + 1)
)(
  input  logic                   clk,
  input  logic                   reset,

  input  logic                   cur_sd,
  input  logic                   net_val,
  output logic                   net_rdy,
  input  logic [m-1:0]           net_msg,

  output logic                   out_val_0,
  input  logic                   out_rdy_0,
  output logic [m-1:0]           out_msg_0,

  output logic                   out_val_1,
  input  logic                   out_rdy_1,
  output logic [m-1:0]           out_msg_1,

  output logic [c_cnt_nbits-1:0] count_0,
  output logic [c_cnt_nbits-1:0] count_1
);

  localparam int unsigned c_num_sd    = 2;
  localparam int unsigned c_ptr_nbits = $clog2(p_num_entries);

  localparam logic [c_cnt_nbits-1:0] c_full = c_cnt_nbits'(p_num_entries);
  localparam logic [c_ptr_nbits-1:0] c_last = c_ptr_nbits'(p_num_entries - 1);

  // Per-domain FIFO state, indexed by security domain
  logic [m-1:0]           storage [c_num_sd][p_num_entries];
  logic [c_ptr_nbits-1:0] enq_ptr [c_num_sd];
  logic [c_ptr_nbits-1:0] deq_ptr [c_num_sd];
  logic [c_cnt_nbits-1:0] count   [c_num_sd];

  logic                   enq_go;
  logic [c_num_sd-1:0]    enq_sd;
  logic [c_num_sd-1:0]    deq_go;
  logic [c_num_sd-1:0]    not_empty;

  // Pointer advance with explicit wrap at the last entry
  function automatic logic [c_ptr_nbits-1:0] ptr_inc(
    input logic [c_ptr_nbits-1:0] ptr
  );
    return (ptr == c_last) ? '0 : c_ptr_nbits'(ptr + c_ptr_nbits'(1));
  endfunction

  //----------------------------------------------------------------------
  // Handshake decode
  //----------------------------------------------------------------------

  // net_rdy looks only at the cur_sd FIFO's fullness; a full FIFO being
  // drained this cycle still refuses, keeping the consumer side out of it.
  always_comb begin
    net_rdy      = (count[cur_sd] != c_full);
    enq_go       = net_val && net_rdy;
    enq_sd       = '0;
    enq_sd[0]    = enq_go && (cur_sd == 1'b0);
    enq_sd[1]    = enq_go && (cur_sd == 1'b1);
    not_empty[0] = (count[0] != '0);
    not_empty[1] = (count[1] != '0);
    deq_go       = '0;
    deq_go[0]    = not_empty[0] && out_rdy_0;
    deq_go[1]    = not_empty[1] && out_rdy_1;
  end

  //----------------------------------------------------------------------
  // FIFO state update
  //----------------------------------------------------------------------

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int d = 0; d < c_num_sd; d++) begin
        enq_ptr[d] <= '0;
        deq_ptr[d] <= '0;
        count[d]   <= '0;
        for (int e = 0; e < p_num_entries; e++) begin
          storage[d][e] <= '0;
        end
      end
    end
    else begin
      for (int d = 0; d < c_num_sd; d++) begin
        if (enq_sd[d]) begin
          storage[d][enq_ptr[d]] <= net_msg;
          enq_ptr[d]             <= ptr_inc(enq_ptr[d]);
        end

        if (deq_go[d]) begin
          deq_ptr[d] <= ptr_inc(deq_ptr[d]);
        end

        // Simultaneous enqueue and dequeue leaves the count unchanged
        case ({enq_sd[d], deq_go[d]})
          2'b10:   count[d] <= c_cnt_nbits'(count[d] + c_cnt_nbits'(1));
          2'b01:   count[d] <= c_cnt_nbits'(count[d] - c_cnt_nbits'(1));
          default: count[d] <= count[d];
        endcase
      end
    end
  end

  //----------------------------------------------------------------------
  // Consumer-side outputs (heads are zeroed when a FIFO is empty)
  //----------------------------------------------------------------------

  always_comb begin
    out_val_0 = not_empty[0];
    out_val_1 = not_empty[1];
    out_msg_0 = not_empty[0] ? storage[0][deq_ptr[0]] : '0;
    out_msg_1 = not_empty[1] ? storage[1][deq_ptr[1]] : '0;
    count_0   = count[0];
    count_1   = count[1];
  end

endmodule

// File: tb/tb_plab4_net_sd_eject_buf.sv
//------------------------------------------------------------------------
// tb_plab4_net_sd_eject_buf
//------------------------------------------------------------------------
// Directed scenarios followed by randomized traffic, all checked against a
// queue-based model of the two per-domain FIFOs.
//------------------------------------------------------------------------

module tb_plab4_net_sd_eject_buf;

  localparam int unsigned M  = 41;
  localparam int unsigned N  = 2;
  localparam int unsigned CW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          cur_sd;
  logic          net_val;
  logic          net_rdy;
  logic [M-1:0]  net_msg;
  logic          out_val_0, out_rdy_0;
  logic [M-1:0]  out_msg_0;
  logic          out_val_1, out_rdy_1;
  logic [M-1:0]  out_msg_1;
  logic [CW-1:0] count_0, count_1;

  always #5 clk = ~clk;

  plab4_net_sd_eject_buf dut (
    .clk       (clk),
    .reset     (reset),
    .cur_sd    (cur_sd),
    .net_val   (net_val),
    .net_rdy   (net_rdy),
    .net_msg   (net_msg),
    .out_val_0 (out_val_0),
    .out_rdy_0 (out_rdy_0),
    .out_msg_0 (out_msg_0),
    .out_val_1 (out_val_1),
    .out_rdy_1 (out_rdy_1),
    .out_msg_1 (out_msg_1),
    .count_0   (count_0),
    .count_1   (count_1)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: one arrival-ordered queue per domain
  logic [M-1:0] q0[$];
  logic [M-1:0] q1[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic          exp_rdy;
    logic [M-1:0]  head0, head1;
    exp_rdy = cur_sd ? (q1.size() != N) : (q0.size() != N);
    head0   = (q0.size() != 0) ? q0[0] : '0;
    head1   = (q1.size() != 0) ? q1[0] : '0;
    chk("net_rdy",   64'(net_rdy),   64'(exp_rdy));
    chk("out_val_0", 64'(out_val_0), 64'(q0.size() != 0));
    chk("out_val_1", 64'(out_val_1), 64'(q1.size() != 0));
    chk("out_msg_0", 64'(out_msg_0), 64'(head0));
    chk("out_msg_1", 64'(out_msg_1), 64'(head1));
    chk("count_0",   64'(count_0),   64'(q0.size()));
    chk("count_1",   64'(count_1),   64'(q1.size()));
  endtask

  // One cycle: drive, check mid-cycle, advance model after the edge
  task automatic step(input logic sd, input logic nv, input logic [M-1:0] msg,
                      input logic r0, input logic r1);
    logic enq, d0, d1;
    cur_sd    = sd;
    net_val   = nv;
    net_msg   = msg;
    out_rdy_0 = r0;
    out_rdy_1 = r1;
    @(negedge clk);
    check_outputs();
    enq = nv && (sd ? (q1.size() != N) : (q0.size() != N));
    d0  = r0 && (q0.size() != 0);
    d1  = r1 && (q1.size() != 0);
    @(posedge clk);
    #1;
    if (d0) void'(q0.pop_front());
    if (d1) void'(q1.pop_front());
    if (enq) begin
      if (sd) q1.push_back(msg);
      else    q0.push_back(msg);
    end
  endtask

  logic [M-1:0] rmsg;

  initial begin
    reset     = 1'b1;
    cur_sd    = 1'b0;
    net_val   = 1'b0;
    net_msg   = '0;
    out_rdy_0 = 1'b0;
    out_rdy_1 = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    step(0, 0, '0, 0, 0);

    // Single message on domain 0 appears next cycle
    step(0, 1, M'(64'hAB), 0, 0);
    chk("t1_val0", 64'(out_val_0), 64'd1);
    chk("t1_msg0", 64'(out_msg_0), 64'hAB);
    chk("t1_cnt0", 64'(count_0),   64'd1);
    chk("t1_val1", 64'(out_val_1), 64'd0);
    step(0, 0, '0, 1, 0);

    // Interleaved domains with both consumers stalled
    step(0, 1, M'(64'hA), 0, 0);
    step(1, 1, M'(64'hB), 0, 0);
    step(0, 1, M'(64'hC), 0, 0);
    step(1, 1, M'(64'hD), 0, 0);
    chk("t2_cnt0", 64'(count_0),   64'd2);
    chk("t2_cnt1", 64'(count_1),   64'd2);
    chk("t2_msg0", 64'(out_msg_0), 64'hA);
    chk("t2_msg1", 64'(out_msg_1), 64'hB);
    step(0, 1, M'(64'hE), 0, 0);
    step(1, 1, M'(64'hE), 0, 0);
    step(0, 0, '0, 1, 0);
    chk("t2_msg0_c", 64'(out_msg_0), 64'hC);
    step(0, 0, '0, 1, 0);
    chk("t2_cnt0_e", 64'(count_0),   64'd0);
    chk("t2_cnt1_h", 64'(count_1),   64'd2);
    chk("t2_msg1_h", 64'(out_msg_1), 64'hB);

    // Full domain 1 refuses even while being drained
    step(1, 1, M'(64'hF), 0, 1);
    chk("t3_cnt1", 64'(count_1), 64'd1);
    step(1, 1, M'(64'hF), 0, 0);
    chk("t3_cnt1_b", 64'(count_1), 64'd2);

    // Streaming enqueue+dequeue on domain 0, pointers wrap
    step(0, 1, M'(64'h10), 0, 0);
    for (int k = 1; k <= 5; k++) step(0, 1, M'(k), 1, 0);
    chk("t4_cnt0", 64'(count_0),   64'd1);
    chk("t4_msg0", 64'(out_msg_0), 64'd5);

    // Async reset mid-cycle with count_0=2, count_1=1
    step(0, 1, M'(64'h20), 0, 1);
    chk("t5_pre0", 64'(count_0), 64'd2);
    chk("t5_pre1", 64'(count_1), 64'd1);
    net_val = 1'b0;
    out_rdy_0 = 1'b0;
    out_rdy_1 = 1'b0;
    #2 reset = 1'b1;
    #1;
    q0.delete();
    q1.delete();
    check_outputs();
    #1 reset = 1'b0;
    step(0, 0, '0, 0, 0);
    step(1, 0, '0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rmsg = M'({$urandom(), $urandom()});
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), rmsg,
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
